// File: rtl/line_buffer_ctrl_pkg.sv
// Shared constants and FSM state encoding for the line-buffer sequencer.
package line_buffer_ctrl_pkg;

   localparam int unsigned DEF_KERNEL_SIZE = 3;
   localparam int unsigned FEATURE_WIDTH   = 8;
   localparam int unsigned KSIZE_WIDTH     = 3;
   localparam int unsigned TN              = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_RUN    = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_SWITCH = 3'd4
   } lb_state_e;

endpackage

// File: rtl/lb_rc_counter.sv
// Row/column scan counter over an N x N tile; col wraps at N-1 and carries into row.
module lb_rc_counter
   import line_buffer_ctrl_pkg::*;
#(
   parameter int unsigned W = FEATURE_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] n,
   output logic [W-1:0] row,
   output logic [W-1:0] col,
   output logic         last_col_c,
   output logic         last_row_c
);

   assign last_col_c = (col == n - W'(1));
   assign last_row_c = (row == n - W'(1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (last_col_c) begin
            col <= '0;
            row <= last_row_c ? '0 : row + W'(1);
         end else begin
            col <= col + W'(1);
         end
      end
   end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Tile sequencer: fills K-1 rows, streams the rest gated by compute_ready,
// flags KxK windows and hands ping-pong buffers back once consumed.
module line_buffer_ctrl
   import line_buffer_ctrl_pkg::*;
#(
   parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int unsigned MAX_FEATURE = 255,
   parameter int unsigned ADDR_WIDTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [KSIZE_WIDTH-1:0]   current_kernel_size,
   input  logic [FEATURE_WIDTH-1:0] feature_size,
   input  logic [1:0]               buf_ready,
   input  logic                     compute_ready,
   output logic                     mem_read_en,
   output logic [ADDR_WIDTH-1:0]    mem_read_addr,
   output logic                     input_buffer_select,
   output logic                     line_buffer_enable,
   output logic                     line_buffer_mod,
   output logic                     window_valid,
   output logic [1:0]               buf_release,
   output logic                     busy,
   output logic                     cfg_error
);

   localparam int unsigned CNT_W = $clog2(MAX_FEATURE + 1);

   lb_state_e              state_q, state_d;
   logic [KSIZE_WIDTH-1:0] k_q;
   logic [CNT_W-1:0]       n_q;
   logic [CNT_W-1:0]       row, col, col_s1;
   logic                   last_col_c, last_row_c;
   logic                   rd_c, cnt_clr_c, rel_c, cfg_err_c, latch_c, tog_c;
   logic                   cfg_bad_c, mod_s1;
   logic [CNT_W-1:0]       k_m1_c, k_m2_c;
   logic [ADDR_WIDTH-1:0]  addr_c;

   lb_rc_counter #(.W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr_c),
      .en         (rd_c),
      .n          (n_q),
      .row        (row),
      .col        (col),
      .last_col_c (last_col_c),
      .last_row_c (last_row_c)
   );

   assign k_m1_c = CNT_W'(k_q) - CNT_W'(1);
   assign k_m2_c = CNT_W'(k_q) - CNT_W'(2);
   assign addr_c = ADDR_WIDTH'(ADDR_WIDTH'(row) * ADDR_WIDTH'(n_q)) + ADDR_WIDTH'(col);

   assign cfg_bad_c = (current_kernel_size == '0) ||
                      (32'(current_kernel_size) > KERNEL_SIZE) ||
                      (CNT_W'(feature_size) < CNT_W'(current_kernel_size));

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_d   = state_q;
      rd_c      = 1'b0;
      cnt_clr_c = 1'b0;
      rel_c     = 1'b0;
      cfg_err_c = 1'b0;
      latch_c   = 1'b0;
      tog_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clr_c = 1'b1;
            if (start && buf_ready[input_buffer_select]) begin
               latch_c = 1'b1;
               if (cfg_bad_c) cfg_err_c = 1'b1;
               else state_d = (current_kernel_size == KSIZE_WIDTH'(1)) ? ST_RUN : ST_FILL;
            end
         end
         ST_FILL: begin
            rd_c = 1'b1;
            if (row == k_m2_c && last_col_c) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (compute_ready) begin
               rd_c = 1'b1;
               if (last_row_c && last_col_c) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: state_d = ST_SWITCH;
         ST_SWITCH: begin
            rel_c     = 1'b1;
            tog_c     = 1'b1;
            cnt_clr_c = 1'b1;
            if (buf_ready[!input_buffer_select])
               state_d = (k_q == KSIZE_WIDTH'(1)) ? ST_RUN : ST_FILL;
            else
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs and the one-cycle read-to-shift delay pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         input_buffer_select <= 1'b0;
         k_q                 <= '0;
         n_q                 <= '0;
         mem_read_en         <= 1'b0;
         mem_read_addr       <= '0;
         mod_s1              <= 1'b0;
         col_s1              <= '0;
         line_buffer_enable  <= 1'b0;
         line_buffer_mod     <= 1'b0;
         window_valid        <= 1'b0;
         buf_release         <= 2'b00;
         busy                <= 1'b0;
         cfg_error           <= 1'b0;
      end else begin
         input_buffer_select <= input_buffer_select ^ tog_c;
         if (latch_c) begin
            k_q <= current_kernel_size;
            n_q <= CNT_W'(feature_size);
         end
         mem_read_en <= rd_c;
         if (rd_c) mem_read_addr <= addr_c;
         mod_s1             <= (state_q == ST_RUN);
         col_s1             <= col;
         line_buffer_enable <= mem_read_en;
         line_buffer_mod    <= mod_s1;
         window_valid       <= mem_read_en & mod_s1 & (col_s1 >= k_m1_c);
         buf_release        <= {rel_c & input_buffer_select, rel_c & ~input_buffer_select};
         busy               <= (state_d != ST_IDLE);
         cfg_error          <= cfg_err_c;
      end
   end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed + randomized bench for line_buffer_ctrl against a tile-level reference model.
module tb_line_buffer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  current_kernel_size = 3'd0;
   logic [7:0]  feature_size = 8'd0;
   logic [1:0]  buf_ready = 2'b00;
   logic        compute_ready = 1'b1;
   logic        mem_read_en;
   logic [15:0] mem_read_addr;
   logic        input_buffer_select;
   logic        line_buffer_enable;
   logic        line_buffer_mod;
   logic        window_valid;
   logic [1:0]  buf_release;
   logic        busy;
   logic        cfg_error;

   int vectors = 0;
   int miscompares = 0;
   int rd_q[$];
   int mod_q[$];
   int win_cnt = 0, rel0 = 0, rel1 = 0, cfg_cnt = 0;
   int busy_seen = 0;
   int prev_rd = 0;
   int cr_mode = 0;

   line_buffer_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .current_kernel_size (current_kernel_size),
      .feature_size        (feature_size),
      .buf_ready           (buf_ready),
      .compute_ready       (compute_ready),
      .mem_read_en         (mem_read_en),
      .mem_read_addr       (mem_read_addr),
      .input_buffer_select (input_buffer_select),
      .line_buffer_enable  (line_buffer_enable),
      .line_buffer_mod     (line_buffer_mod),
      .window_valid        (window_valid),
      .buf_release         (buf_release),
      .busy                (busy),
      .cfg_error           (cfg_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Event logger, sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         prev_rd = int'(mem_read_en);
      end else begin
         check("lbe_delay", int'(line_buffer_enable), prev_rd);
         prev_rd = int'(mem_read_en);
         if (mem_read_en) rd_q.push_back(int'(mem_read_addr));
         if (line_buffer_enable) mod_q.push_back(int'(line_buffer_mod));
         if (window_valid) win_cnt++;
         if (buf_release[0]) rel0++;
         if (buf_release[1]) rel1++;
         if (cfg_error) cfg_cnt++;
         if (busy) busy_seen = 1;
      end
   end

   // compute_ready pattern: 0 = always ready, 1 = toggling, 2 = random.
   initial forever begin
      @(negedge clk);
      case (cr_mode)
         0:       compute_ready = 1'b1;
         1:       compute_ready = ~compute_ready;
         default: compute_ready = 1'($urandom_range(0, 1));
      endcase
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      rd_q.delete();
      mod_q.delete();
      win_cnt = 0; rel0 = 0; rel1 = 0; cfg_cnt = 0; busy_seen = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      tick(2);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic pulse_start(input int k, input int n);
      current_kernel_size = 3'(k);
      feature_size = 8'(n);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int cnt;
      cnt = 0;
      tick(1);
      while (busy && cnt < budget) begin
         tick(1);
         cnt++;
      end
      check("done_in_time", int'(busy), 0);
      tick(4);
   endtask

   // Reference: each tile reads every (r,c) in raster order, run phase from row K-1,
   // (N-K+1)^2 windows and one release of the buffer it came from.
   task automatic check_tiles(input int k, input int n, input int tiles,
                              input int exp_rel0, input int exp_rel1, input int exp_sel);
      int idx;
      check("read_count", rd_q.size(), tiles * n * n);
      check("mod_count", mod_q.size(), tiles * n * n);
      for (int t = 0; t < tiles; t++)
         for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
               idx = (t * n + r) * n + c;
               if (idx < rd_q.size())  check("addr", rd_q[idx], r * n + c);
               if (idx < mod_q.size()) check("mod", mod_q[idx], (r >= k - 1) ? 1 : 0);
            end
      check("windows", win_cnt, tiles * (n - k + 1) * (n - k + 1));
      check("release0", rel0, exp_rel0);
      check("release1", rel1, exp_rel1);
      check("sel", int'(input_buffer_select), exp_sel);
      check("busy_end", int'(busy), 0);
      check("cfg_err_none", cfg_cnt, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, int'({mem_read_en, mem_read_addr, input_buffer_select, line_buffer_enable,
                       line_buffer_mod, window_valid, buf_release, busy, cfg_error}), 0);
   endtask

   initial begin
      int cnt, k, n;

      do_reset();
      check_all_zero("reset_state");

      // Single tile, buffer 0 only.
      buf_ready = 2'b01;
      cr_mode = 0;
      pulse_start(3, 5);
      wait_done(500);
      check_tiles(3, 5, 1, 1, 0, 1);

      // Both buffers full: second tile runs without a new start.
      do_reset();
      buf_ready = 2'b11;
      pulse_start(3, 5);
      cnt = 0;
      while (rel0 == 0 && cnt < 500) begin
         tick(1);
         cnt++;
      end
      check("release0_seen", rel0, 1);
      buf_ready[0] = 1'b0;
      wait_done(500);
      check_tiles(3, 5, 2, 1, 1, 0);

      // Toggling compute_ready; a start while busy must be ignored.
      do_reset();
      buf_ready = 2'b01;
      cr_mode = 1;
      pulse_start(3, 5);
      tick(3);
      pulse_start(1, 4);
      wait_done(500);
      check_tiles(3, 5, 1, 1, 0, 1);

      // K=1: no fill phase.
      do_reset();
      cr_mode = 0;
      pulse_start(1, 4);
      wait_done(500);
      check_tiles(1, 4, 1, 1, 0, 1);

      // Rejected configurations and a start on an empty buffer.
      do_reset();
      pulse_start(4, 5);
      tick(3);
      check("cfg_err_k4", cfg_cnt, 1);
      pulse_start(3, 2);
      tick(3);
      check("cfg_err_n2", cfg_cnt, 2);
      pulse_start(0, 5);
      tick(3);
      check("cfg_err_k0", cfg_cnt, 3);
      buf_ready = 2'b00;
      pulse_start(3, 5);
      tick(3);
      check("cfg_err_total", cfg_cnt, 3);
      check("busy_never", busy_seen, 0);
      check("reads_none", rd_q.size(), 0);

      // Reset in the middle of the fill phase.
      do_reset();
      buf_ready = 2'b01;
      pulse_start(3, 5);
      cnt = 0;
      while (rd_q.size() < 7 && cnt < 100) begin
         tick(1);
         cnt++;
      end
      check("seventh_read", rd_q.size(), 7);
      rst = 1'b1;
      tick(1);
      check_all_zero("midtile_reset");
      check("no_release", rel0 + rel1, 0);
      tick(1);
      rst = 1'b0;
      clear_logs();
      pulse_start(3, 5);
      wait_done(500);
      check_tiles(3, 5, 1, 1, 0, 1);

      // Randomized configurations with random compute_ready.
      for (int it = 0; it < 6; it++) begin
         do_reset();
         buf_ready = 2'b01;
         cr_mode = 2;
         k = int'($urandom_range(1, 3));
         n = int'($urandom_range(k, 9));
         pulse_start(k, n);
         wait_done(2000);
         check_tiles(k, n, 1, 1, 0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
